mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 resetn  in  1  asynchronous active-low reset.
REQ-004 start  in  1  operation request from execute stage, sampled only in IDLE.
REQ-005 op  in  3  operation code of type mdu_op_t: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-006 src_a  in  32  rs operand / dividend / multiplicand.
REQ-007 src_b  in  32  rt operand / divisor / multiplier.
REQ-008 flush  in  1  abort in-flight operation.
REQ-009 busy  out  1  stall request to pipeline, high whenever state != IDLE.
REQ-010 done  out  1  one-cycle pulse, high in the cycle after hi/lo commit of a MULT/MULTU/DIV/DIVU.
REQ-011 hi  out  32  architectural HI register.
REQ-012 lo  out  32  architectural LO register.

Function
REQ-013 States SHALL be IDLE, MUL, DIV, FIX; encoding from mdu_state_t.
REQ-014 IDLE + start + MTHI/MTLO: hi (resp. lo) SHALL take src_a at that edge; state stays IDLE; no busy, no done.
REQ-015 IDLE + start + MULT/MULTU: operands latched; state SHALL go to MUL; iteration counter cleared to 0.
REQ-016 IDLE + start + DIV/DIVU: operands latched; state SHALL go to DIV; counter cleared to 0.
REQ-017 IDLE + start + NONE: no state change.
REQ-018 Signed ops: magnitudes SHALL be latched, with result signs recorded at start.
REQ-019 MUL/DIV: one radix-2 step per cycle; 32 steps; after the 32nd step (count 31) the state SHALL go to FIX.
REQ-020 FIX: sign correction applied; hi/lo written at the FIX->IDLE edge; done high in the following cycle.
REQ-021 Latency: start edge to hi/lo visible SHALL be 34 edges; busy high for exactly 33 cycles.
REQ-022 Multiply result: hi:lo = 64-bit product; signed product negated when operand signs differ.
REQ-023 Divide result: lo = quotient, hi = remainder.
REQ-024 Divide signs: quotient negative iff operand signs differ; remainder takes the sign of the dividend.
REQ-025 Divide by zero, signed or unsigned, SHALL give lo=32'hFFFF_FFFF and hi=src_a; latency unchanged.
REQ-026 Signed 32'h8000_0000 / 32'hFFFF_FFFF SHALL give lo=32'h8000_0000, hi=0.
REQ-027 start while busy SHALL be ignored.
REQ-028 flush SHALL have priority over start: next state IDLE, hi/lo unchanged, done not asserted.
REQ-029 flush in IDLE with start SHALL drop the request, including MTHI/MTLO.

Reset
REQ-030 resetn low SHALL immediately force: state IDLE, counter 0, hi=0, lo=0, busy=0, done=0, latched operands 0.
REQ-031 Reset mid-operation SHALL discard the operation with no done pulse.

Configuration
REQ-032 Macro MDU_FAST_MUL_EN defined: MULT/MULTU SHALL compute the full product combinationally and write hi/lo at the start edge; state stays IDLE; busy never asserted; done pulses next cycle.
REQ-033 Macro undefined: MULT/MULTU SHALL use the 32-step MUL path of REQ-019..REQ-022.
REQ-034 Divide behaviour SHALL be identical with or without the macro.

Structure
REQ-035 mdu_op_t and mdu_state_t SHALL reside in the shared package header, alongside existing icode/acode constants.
REQ-036 DIV_STEPS = 32 SHALL be a package constant.
REQ-037 The restoring-divide step SHALL be a sub-module div_step: combinational, 64-bit partial remainder + divisor in, next remainder + quotient bit out.

Verification
REQ-038 Reset then MTHI src_a=32'h1234_5678 -> hi=32'h1234_5678 next cycle, busy stays 0.
REQ-039 MULT src_a=-3, src_b=7 (macro off) -> busy 33 cycles, then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB, done 1 cycle.
REQ-040 DIV src_a=-7, src_b=2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF after 34 edges.
REQ-041 DIVU src_a=5, src_b=0 -> lo=32'hFFFF_FFFF, hi=5.
REQ-042 DIVU 100/7 started, flush at step 10 -> IDLE next edge, hi/lo keep prior values, no done.
REQ-043 MDU_FAST_MUL_EN defined, MULTU 32'hFFFF_FFFF x 2 -> hi=1, lo=32'hFFFF_FFFE after 1 edge, busy never high.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mdu_ctrl_pkg -- shared MDU definitions.
//
// Holds the instruction-field constants used by decode (icode/acode), the
// operation code handed to the multiply/divide unit, the controller state
// encoding and the iteration-count constants shared by the MUL and DIV paths.
// -----------------------------------------------------------------------------
package mdu_ctrl_pkg;

  // Primary opcode and SPECIAL-group function codes of the HI/LO instructions.
  localparam logic [5:0] ICODE_SPECIAL = 6'h00;
  localparam logic [5:0] ACODE_MFHI    = 6'h10;
  localparam logic [5:0] ACODE_MTHI    = 6'h11;
  localparam logic [5:0] ACODE_MFLO    = 6'h12;
  localparam logic [5:0] ACODE_MTLO    = 6'h13;
  localparam logic [5:0] ACODE_MULT    = 6'h18;
  localparam logic [5:0] ACODE_MULTU   = 6'h19;
  localparam logic [5:0] ACODE_DIV     = 6'h1A;
  localparam logic [5:0] ACODE_DIVU    = 6'h1B;

  // Operation requested by the execute stage.
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } mdu_op_t;

  // Controller state encoding (kept as plain constants for legacy users).
  typedef logic [1:0] mdu_state_t;
  localparam mdu_state_t S_IDLE = 2'd0;
  localparam mdu_state_t S_MUL  = 2'd1;
  localparam mdu_state_t S_DIV  = 2'd2;
  localparam mdu_state_t S_FIX  = 2'd3;

  // One radix-2 step per cycle; multiply uses the same step count.
  localparam int DIV_STEPS = 32;
  localparam int CNT_W     = $clog2(DIV_STEPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_STEPS - 1);

  // Map a SPECIAL-group function code onto the MDU operation it requests.
  function automatic mdu_op_t mdu_op_from_acode(input logic [5:0] acode);
    mdu_op_t res;
    res = OP_NONE;
    case (acode)
      ACODE_MULT:  res = OP_MULT;
      ACODE_MULTU: res = OP_MULTU;
      ACODE_DIV:   res = OP_DIV;
      ACODE_DIVU:  res = OP_DIVU;
      ACODE_MTHI:  res = OP_MTHI;
      ACODE_MTLO:  res = OP_MTLO;
      default:     res = OP_NONE;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mdu_ctrl_div_step.sv
// -----------------------------------------------------------------------------
// div_step -- one restoring-division step (purely combinational).
//
// The 64-bit partial remainder is {remainder[31:0], unconsumed dividend bits}.
// Each step shifts it left by one, tries to subtract the divisor from the top
// 33 bits and keeps the difference when it does not borrow.
//
// Ports:
//   rem_in   in  64  current partial remainder / dividend shift register
//   divisor  in  32  divisor magnitude
//   rem_out  out 64  next partial remainder, quotient bit in bit 0
//   q_bit    out 1   quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step (
  input  logic [63:0] rem_in,
  input  logic [31:0] divisor,
  output logic [63:0] rem_out,
  output logic        q_bit
);

  logic [32:0] trial;
  logic [31:0] diff;

  // Remainder stays below the divisor, so the shifted trial value fits in
  // 33 bits and the accepted difference always fits back into 32.
  assign trial = rem_in[63:31];
  assign q_bit = (trial >= {1'b0, divisor});
  assign diff  = trial[31:0] - divisor;

  assign rem_out = q_bit ? {diff, rem_in[30:0], 1'b1}
                         : {rem_in[62:0], 1'b0};

endmodule

// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl -- iterative multiply/divide unit with architectural HI/LO.
//
// MULT/MULTU run a 32-step shift-add multiply, DIV/DIVU a 32-step restoring
// divide, both on operand magnitudes; the FIX state applies the recorded
// signs and commits HI/LO. MTHI/MTLO write HI/LO directly from IDLE.
//
// Configuration macro:
//   MDU_FAST_MUL_EN  when defined, MULT/MULTU are computed combinationally
//                    and committed at the start edge (no busy, done next
//                    cycle). Divide is unaffected.
//
// Ports:
//   clk     in  1   clock, rising edge
//   resetn  in  1   asynchronous active-low reset
//   start   in  1   operation request, sampled only in IDLE
//   op      in  3   mdu_op_t operation code
//   src_a   in  32  rs / dividend / multiplicand
//   src_b   in  32  rt / divisor / multiplier
//   flush   in  1   abort in-flight operation (priority over start)
//   busy    out 1   stall request, high whenever not IDLE
//   done    out 1   one-cycle pulse after a MULT/MULTU/DIV/DIVU commit
//   hi      out 32  architectural HI
//   lo      out 32  architectural LO
// -----------------------------------------------------------------------------
module mdu_ctrl
  import mdu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  mdu_op_t     op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      acc_q;    // product / partial-remainder shift register
  logic [31:0]      opnd_q;   // multiplicand / divisor magnitude
  logic             neg_q_q;  // negate product or quotient in FIX
  logic             neg_r_q;  // negate remainder in FIX
  logic             div0_q;   // divide by zero: force quotient to all ones
  logic             is_div_q;
  logic [31:0]      hi_q, lo_q;
  logic             done_q;

  // ---------------------------------------------------------------------------
  // Operand magnitudes and result signs, evaluated at the start edge.
  // ---------------------------------------------------------------------------
  logic        signed_op;
  logic [31:0] mag_a, mag_b;

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign mag_a     = (signed_op && src_a[31]) ? (32'd0 - src_a) : src_a;
  assign mag_b     = (signed_op && src_b[31]) ? (32'd0 - src_b) : src_b;

  // ---------------------------------------------------------------------------
  // Multiply step: add multiplicand into the upper half when the current
  // multiplier bit (acc[0]) is set, then shift the 65-bit result right.
  // ---------------------------------------------------------------------------
  logic [32:0] mul_sum;
  logic [63:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // ---------------------------------------------------------------------------
  // Divide step.
  // ---------------------------------------------------------------------------
  logic [63:0] div_rem;
  logic        div_q;
  logic [63:0] div_next;

  div_step u_div_step (
    .rem_in  (acc_q),
    .divisor (opnd_q),
    .rem_out (div_rem),
    .q_bit   (div_q)
  );

  assign div_next = div_rem | {63'd0, div_q};

  // ---------------------------------------------------------------------------
  // Sign correction applied in FIX. A zero divisor leaves the dividend
  // magnitude as the remainder, so restoring the dividend sign yields src_a.
  // ---------------------------------------------------------------------------
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;

  assign prod_fix = neg_q_q ? (64'd0 - acc_q) : acc_q;
  assign quot_fix = div0_q  ? 32'hFFFF_FFFF
                  : (neg_q_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0]);
  assign rem_fix  = neg_r_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

`ifdef MDU_FAST_MUL_EN
  // Low 64 bits of the product of the 64-bit extended operands equal the
  // signed (or unsigned) product, so one unsigned multiplier serves both.
  logic [63:0] ext_a, ext_b, fast_prod;

  assign ext_a     = {{32{signed_op & src_a[31]}}, src_a};
  assign ext_b     = {{32{signed_op & src_b[31]}}, src_b};
  assign fast_prod = ext_a * ext_b;
`endif

  // ---------------------------------------------------------------------------
  // Controller and HI/LO state.
  // ---------------------------------------------------------------------------
  // NOTE: all state, including the operand latches, is cleared by reset so
  // an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; done defaults low so it
      // is a single-cycle pulse.
      done_q <= 1'b0;
      if (flush) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              case (op)
                OP_MTHI: hi_q <= src_a;
                OP_MTLO: lo_q <= src_a;
                OP_MULT, OP_MULTU: begin
`ifdef MDU_FAST_MUL_EN
                  hi_q   <= fast_prod[63:32];
                  lo_q   <= fast_prod[31:0];
                  done_q <= 1'b1;
`else
                  state_q  <= S_MUL;
                  cnt_q    <= '0;
                  acc_q    <= {32'd0, mag_b};
                  opnd_q   <= mag_a;
                  neg_q_q  <= signed_op & (src_a[31] ^ src_b[31]);
                  neg_r_q  <= 1'b0;
                  div0_q   <= 1'b0;
                  is_div_q <= 1'b0;
`endif
                end
                OP_DIV, OP_DIVU: begin
                  state_q  <= S_DIV;
                  cnt_q    <= '0;
                  acc_q    <= {32'd0, mag_a};
                  opnd_q   <= mag_b;
                  neg_q_q  <= signed_op & (src_a[31] ^ src_b[31]);
                  neg_r_q  <= signed_op & src_a[31];
                  div0_q   <= (src_b == 32'd0);
                  is_div_q <= 1'b1;
                end
                default: ;
              endcase
            end
          end
          S_MUL: begin
            acc_q <= mul_next;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_q <= S_FIX;
          end
          S_DIV: begin
            acc_q <= div_next;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_q <= S_FIX;
          end
          S_FIX: begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b1;
            if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end else begin
              hi_q <= prod_fix[63:32];
              lo_q <= prod_fix[31:0];
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdu_ctrl -- self-checking bench for mdu_ctrl: a table of directed
// operations with hand-computed HI/LO, busy length and done, followed by
// hand-written flush, start-while-busy and reset-mid-operation sequences.
// -----------------------------------------------------------------------------
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_CYC = 0;
`else
  localparam int MUL_CYC = 33;
`endif
  localparam int OP_CYC = 33;
  localparam int NV     = 16;

  logic        clk;
  logic        resetn;
  logic        start;
  mdu_op_t     op;
  logic [31:0] src_a, src_b;
  logic        flush;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    mdu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    logic        done;
  } vec_t;

  vec_t vec [NV];

  mdu_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count cycles with busy high, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    int seen;

    //              op        src_a          src_b          hi             lo             cyc      done
    vec[0]  = '{OP_MTHI,  32'h1234_5678, 32'h0,         32'h1234_5678, 32'h0,         0,       1'b0};
    vec[1]  = '{OP_MTLO,  32'hCAFE_BABE, 32'h0,         32'h1234_5678, 32'hCAFE_BABE, 0,       1'b0};
    vec[2]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_CYC, 1'b1};
    vec[3]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, MUL_CYC, 1'b1};
    vec[4]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         MUL_CYC, 1'b1};
    vec[5]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_CYC, 1'b1};
    vec[6]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, OP_CYC,  1'b1};
    vec[7]  = '{OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, OP_CYC,  1'b1};
    vec[8]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, OP_CYC,  1'b1};
    vec[9]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, OP_CYC,  1'b1};
    vec[10] = '{OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, OP_CYC,  1'b1};
    vec[11] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        OP_CYC,  1'b1};
    vec[12] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'h0,         32'hFFFF_FFFF, OP_CYC,  1'b1};
    vec[13] = '{OP_NONE,  32'hDEAD_BEEF, 32'd3,         32'h0,         32'hFFFF_FFFF, 0,       1'b0};
    vec[14] = '{OP_MTHI,  32'h1111_2222, 32'h0,         32'h1111_2222, 32'hFFFF_FFFF, 0,       1'b0};
    vec[15] = '{OP_MTLO,  32'h3333_4444, 32'h0,         32'h1111_2222, 32'h3333_4444, 0,       1'b0};

    resetn = 1'b0;
    start  = 1'b0;
    op     = OP_NONE;
    src_a  = '0;
    src_b  = '0;
    flush  = 1'b0;

    // Reset state, checked while reset is held.
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    resetn = 1'b1;
    tick();

    // Table-driven operations.
    for (int i = 0; i < NV; i++) begin
      start = 1'b1;
      op    = vec[i].op;
      src_a = vec[i].a;
      src_b = vec[i].b;
      tick();
      start = 1'b0;
      op    = OP_NONE;
      wait_idle(n);
      check($sformatf("v%0d busy cycles", i), 32'(n), 32'(vec[i].cyc));
      check($sformatf("v%0d hi", i), hi, vec[i].hi);
      check($sformatf("v%0d lo", i), lo, vec[i].lo);
      check($sformatf("v%0d done", i), 32'(done), 32'(vec[i].done));
      tick();
      check($sformatf("v%0d done cleared", i), 32'(done), 32'd0);
    end

    // Flush at step 10 of DIVU 100/7: back to IDLE, HI/LO kept, no done.
    start = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
    tick();
    start = 1'b0; op = OP_NONE;
    repeat (10) tick();
    check("flush pre busy", 32'(busy), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy", 32'(busy), 32'd0);
    check("flush hi", hi, 32'h1111_2222);
    check("flush lo", lo, 32'h3333_4444);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done || busy) seen++;
      tick();
    end
    check("flush no done", 32'(seen), 32'd0);
    check("flush hi after", hi, 32'h1111_2222);

    // Start while busy is ignored (MTHI and a second divide).
    start = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
    tick();
    start = 1'b0; op = OP_NONE;
    repeat (4) tick();
    start = 1'b1; op = OP_MTHI; src_a = 32'hDEAD_0000;
    tick();
    start = 1'b0; op = OP_NONE;
    check("busy mthi hi", hi, 32'h1111_2222);
    check("busy mthi busy", 32'(busy), 32'd1);
    repeat (4) tick();
    start = 1'b1; op = OP_DIVU; src_a = 32'd1000; src_b = 32'd3;
    tick();
    start = 1'b0; op = OP_NONE;
    wait_idle(n);
    check("busy restart cycles", 32'(n), 32'd23);
    check("busy restart hi", hi, 32'd2);
    check("busy restart lo", lo, 32'd14);
    check("busy restart done", 32'(done), 32'd1);
    tick();

    // Flush together with start in IDLE drops MTHI.
    flush = 1'b1; start = 1'b1; op = OP_MTHI; src_a = 32'hFFFF_0000;
    tick();
    flush = 1'b0; start = 1'b0; op = OP_NONE;
    check("idle flush hi", hi, 32'd2);
    check("idle flush busy", 32'(busy), 32'd0);
    check("idle flush done", 32'(done), 32'd0);

    // Reset mid-operation: immediate clear, no done afterwards.
    start = 1'b1; op = OP_DIV; src_a = 32'hFFFF_FFF9; src_b = 32'd2;
    tick();
    start = 1'b0; op = OP_NONE;
    repeat (5) tick();
    #2 resetn = 1'b0;
    #1;
    check("rst mid busy", 32'(busy), 32'd0);
    check("rst mid hi", hi, 32'h0);
    check("rst mid lo", lo, 32'h0);
    check("rst mid done", 32'(done), 32'd0);
    #2 resetn = 1'b1;
    tick();
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done || busy) seen++;
      tick();
    end
    check("rst mid no done", 32'(seen), 32'd0);
    check("rst mid lo after", lo, 32'h0);

    // Unit still works after the mid-operation reset.
    start = 1'b1; op = OP_MULT; src_a = 32'hFFFF_FFFD; src_b = 32'd7;
    tick();
    start = 1'b0; op = OP_NONE;
    wait_idle(n);
    check("post rst cycles", 32'(n), 32'(MUL_CYC));
    check("post rst hi", hi, 32'hFFFF_FFFF);
    check("post rst lo", lo, 32'hFFFF_FFEB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
